// File: rtl/logdrop_window_accum_pkg.sv
// rtl/logdrop_window_accum_pkg.sv - width helpers, MSB helper and FSM state shared by logdrop_window_accum
package logdropPkg;

    function automatic int time_width(input int winlen);
        return $clog2(winlen);
    endfunction

    function automatic int sum_width(input int data_w, input int winlen);
        return data_w + $clog2(winlen);
    endfunction

    // Index of the highest set bit; 0 for an all-zero input.
    function automatic logic [4:0] msb_index(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/logdrop_window_accum_window.sv
// rtl/logdrop_window_accum_window.sv - logdropWindow: y = x >> floor(log2(t)), t = 0 treated as log2 = 0
module logdropWindow
    import logdropPkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int WINLEN         = 256,
    parameter int ABSTRACT_MODEL = 0,
    localparam int TIME_W        = time_width(WINLEN)
) (
    input  logic [TIME_W-1:0] i_t,
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_y
);

    logic [4:0] drop;

    assign drop = msb_index(32'(i_t));

    // Both forms give the same result; the abstract one states the weight as a divide.
    generate
        if (ABSTRACT_MODEL != 0) begin : g_abstract
            assign o_y = DATA_W'(32'(i_x) / (32'd1 << drop));
        end else begin : g_shift
            assign o_y = i_x >> drop;
        end
    endgenerate

endmodule

// File: rtl/logdrop_window_accum.sv
// rtl/logdrop_window_accum.sv - windowed sample accumulator; LOGDROP_WINDOW_ACCUM_RECT_EN selects a rectangular window
module logdrop_window_accum
    import logdropPkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int WINLEN         = 256,
    parameter int ABSTRACT_MODEL = 0,
    localparam int TIME_W        = time_width(WINLEN),
    localparam int SUM_W         = sum_width(DATA_W, WINLEN)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_x,
    input  logic              i_xValid,
    output logic              o_xReady,
    output logic [SUM_W-1:0]  o_sum,
    output logic              o_sumValid,
    input  logic              i_sumReady,
    output logic [TIME_W-1:0] o_t
);

    state_t            state_q;
    logic [TIME_W-1:0] t_q, t_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] y;
    logic              last, accept, consume, complete;

`ifdef LOGDROP_WINDOW_ACCUM_RECT_EN
    assign y = i_x;
`else
    logdropWindow #(
        .DATA_W        (DATA_W),
        .WINLEN        (WINLEN),
        .ABSTRACT_MODEL(ABSTRACT_MODEL)
    ) u_window (
        .i_t(t_q),
        .i_x(i_x),
        .o_y(y)
    );
`endif

    // Only the window-completing sample has to wait for the held sum to drain.
    assign last     = (t_q == TIME_W'(WINLEN - 1));
    assign o_xReady = !((state_q == HOLD) && !i_sumReady && last);
    assign accept   = i_xValid && o_xReady && !i_clear;
    assign complete = accept && last;
    assign consume  = (state_q == HOLD) && i_sumReady;

    always_comb begin
        t_d   = t_q;
        acc_d = acc_q;
        sum_d = sum_q;
        if (i_clear) begin
            t_d   = '0;
            acc_d = '0;
        end else if (accept) begin
            if (last) begin
                sum_d = acc_q + SUM_W'(y);
                acc_d = '0;
                t_d   = '0;
            end else begin
                acc_d = acc_q + SUM_W'(y);
                t_d   = t_q + TIME_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ACCUM;
            t_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            t_q   <= t_d;
            acc_q <= acc_d;
            sum_q <= sum_d;
            case (state_q)
                ACCUM: if (complete) state_q <= HOLD;
                HOLD:  if (consume && !complete) state_q <= ACCUM;
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign o_sum      = sum_q;
    assign o_sumValid = (state_q == HOLD);
    assign o_t        = t_q;

endmodule

// File: tb/tb_logdrop_window_accum.sv
// tb/tb_logdrop_window_accum.sv - table and scoreboard bench for logdrop_window_accum (ABSTRACT_MODEL 0 and 1)
module tb_logdrop_window_accum;

    localparam int DATA_W = 8;
    localparam int WINLEN = 256;
    localparam int TIME_W = 8;
    localparam int SUM_W  = 16;

    typedef struct {
        logic [DATA_W-1:0] x;
        int unsigned       exp_sum;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              x_valid = 1'b0;
    logic              sum_ready = 1'b1;
    logic [DATA_W-1:0] x = '0;
    logic              ready0, ready1, valid0, valid1;
    logic [SUM_W-1:0]  sum0, sum1;
    logic [TIME_W-1:0] t0, t1;

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned exp_q[$];
    int          m_t = 0;
    int unsigned m_acc = 0;
    bit          m_hold = 1'b0;
    vec_t        vecs[4];

    always #5 clk = ~clk;

    logdrop_window_accum #(.DATA_W(DATA_W), .WINLEN(WINLEN), .ABSTRACT_MODEL(0)) u_dut0 (
        .i_clk(clk), .i_arst_n(rst_n), .i_clear(clear), .i_x(x), .i_xValid(x_valid),
        .o_xReady(ready0), .o_sum(sum0), .o_sumValid(valid0), .i_sumReady(sum_ready), .o_t(t0)
    );

    logdrop_window_accum #(.DATA_W(DATA_W), .WINLEN(WINLEN), .ABSTRACT_MODEL(1)) u_dut1 (
        .i_clk(clk), .i_arst_n(rst_n), .i_clear(clear), .i_x(x), .i_xValid(x_valid),
        .o_xReady(ready1), .o_sum(sum1), .o_sumValid(valid1), .i_sumReady(sum_ready), .o_t(t1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned win(input int t, input int unsigned xv);
`ifdef LOGDROP_WINDOW_ACCUM_RECT_EN
        return xv;
`else
        int d;
        d = 0;
        for (int i = 0; i < TIME_W; i++) begin
            if (((t >> i) & 1) != 0) d = i;
        end
        return xv >> d;
`endif
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin : mon
        int unsigned y;
        bit exp_ready, cons, comp;
        if (rst_n) begin
            exp_ready = !(m_hold && !sum_ready && (m_t == WINLEN - 1));
            chk("t_u0", t0, m_t);
            chk("t_u1", t1, m_t);
            chk("valid_u0", valid0, m_hold);
            chk("valid_u1", valid1, m_hold);
            chk("ready_u0", ready0, exp_ready);
            chk("ready_u1", ready1, exp_ready);
            if (m_hold && exp_q.size() > 0) begin
                chk("sum_u0", sum0, exp_q[0]);
                chk("sum_u1", sum1, exp_q[0]);
            end
            cons = m_hold && sum_ready;
            comp = 1'b0;
            if (cons) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else void'(exp_q.pop_front());
            end
            if (clear) begin
                m_t   = 0;
                m_acc = 0;
            end else if (x_valid && exp_ready) begin
                y = win(m_t, x);
                if (m_t == WINLEN - 1) begin
                    exp_q.push_back(m_acc + y);
                    m_acc = 0;
                    m_t   = 0;
                    comp  = 1'b1;
                end else begin
                    m_acc += y;
                    m_t++;
                end
            end
            if (comp) m_hold = 1'b1;
            else if (cons) m_hold = 1'b0;
        end
    end

    task automatic send(input logic [DATA_W-1:0] xv);
        int n;
        bit ok;
        n = 0;
        x = xv;
        x_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = ready0;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic send_rand(input int count);
        for (int i = 0; i < count; i++) send(DATA_W'($urandom));
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_t"}, t0, 0);
        chk({tag, "_valid"}, valid0, 0);
        chk({tag, "_sum"}, sum0, 0);
        chk({tag, "_ready"}, ready0, 1);
        chk({tag, "_t_u1"}, t1, 0);
        chk({tag, "_valid_u1"}, valid1, 0);
        chk({tag, "_sum_u1"}, sum1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef LOGDROP_WINDOW_ACCUM_RECT_EN
        vecs[0] = '{x: 8'd0,   exp_sum: 0};
        vecs[1] = '{x: 8'd1,   exp_sum: 256};
        vecs[2] = '{x: 8'd128, exp_sum: 32768};
        vecs[3] = '{x: 8'd255, exp_sum: 65280};
`else
        vecs[0] = '{x: 8'd0,   exp_sum: 0};
        vecs[1] = '{x: 8'd1,   exp_sum: 2};
        vecs[2] = '{x: 8'd128, exp_sum: 1152};
        vecs[3] = '{x: 8'd255, exp_sum: 2048};
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < WINLEN; i++) send(vecs[v].x);
            chk("tbl_valid", valid0, 1);
            chk("tbl_sum_u0", sum0, vecs[v].exp_sum);
            chk("tbl_sum_u1", sum1, vecs[v].exp_sum);
            chk("tbl_t", t0, 0);
        end
        drain();

        send_rand(2 * WINLEN);
        drain();

        // Held sum, full second window, then the completing sample meets backpressure.
        sum_ready = 1'b0;
        send_rand(WINLEN);
        send_rand(WINLEN - 1);
        x = DATA_W'($urandom);
        x_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("bp_stall_ready", ready0, 0);
        chk("bp_stall_t", t0, WINLEN - 1);
        chk("bp_stall_valid", valid0, 1);
        sum_ready = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        chk("bp_nobubble_valid", valid0, 1);
        chk("bp_nobubble_t", t0, 0);
        chk("bp_queue", exp_q.size(), 1);
        drain();

        // Clear mid-window while a sum is held.
        sum_ready = 1'b0;
        send_rand(WINLEN);
        send_rand(100);
        chk("clr_pre_t", t0, 100);
        chk("clr_pre_valid", valid0, 1);
        clear = 1'b1;
        x = 8'd200;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        x_valid = 1'b0;
        chk("clr_t", t0, 0);
        chk("clr_valid", valid0, 1);
        chk("clr_sum", sum0, exp_q[0]);
        sum_ready = 1'b1;
        send_rand(WINLEN);
        drain();

        // Asynchronous reset mid-window with a pending sum.
        sum_ready = 1'b0;
        send_rand(WINLEN);
        send_rand(37);
        chk("rst_pre_t", t0, 37);
        chk("rst_pre_valid", valid0, 1);
        rst_n = 1'b0;
        exp_q.delete();
        m_t    = 0;
        m_acc  = 0;
        m_hold = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sum_ready = 1'b1;
        send_rand(WINLEN);
        chk("rst_win_t", t0, 0);
        chk("rst_win_valid", valid0, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
